abc: RTL and testbench

- Serial byte repeater. Receives asynchronous 8N1 frames on rxd and re-transmits each valid byte unchanged as an 8N1 frame on txd.
- Receive side oversamples at RX_OVERSAMPLE clocks per bit. Transmit side sends at TX_BIT_CYCLES clocks per bit, so txd runs much faster than rxd.
- Sits between a slow serial source and a fast serial sink; the only state carried between the two sides is a one-byte holding register.

---
 rtl/abc_pkg.sv | 23 ++
 rtl/abc_rx.sv | 85 ++++++++
 rtl/abc.sv | 109 ++++++++++
 tb/tb_abc.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/abc_pkg.sv
// rtl/abc_pkg.sv - shared constants and state encodings for the abc serial byte repeater
package abc_pkg;

   localparam logic MARKING   = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_BITS = 8;

   typedef enum logic [1:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_START,
      T_DATA,
      T_STOP
   } tx_state_t;

endpackage

// File: rtl/abc_rx.sv
// rtl/abc_rx.sv - rxd synchroniser and oversampling 8N1 receiver; emits a byte with a one-clock valid pulse
module abc_rx
   import abc_pkg::*;
#(
   parameter int RX_OVERSAMPLE = 16
) (
   input  logic                 clock,
   input  logic                 reset_,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid
);

   localparam int              CW        = $clog2(RX_OVERSAMPLE);
   localparam logic [CW-1:0]   HALF_LAST = CW'(RX_OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0]   FULL_LAST = CW'(RX_OVERSAMPLE - 1);

   logic                 sync1;
   logic                 rxs;
   rx_state_t            state;
   logic [CW-1:0]        cnt;
   logic [2:0]           bit_cnt;
   logic [DATA_BITS-1:0] shift;

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         sync1   <= MARKING;
         rxs     <= MARKING;
         state   <= R_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         data    <= '0;
         valid   <= 1'b0;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
         valid <= 1'b0;
         case (state)
            R_IDLE: begin
               if (rxs == START_BIT) begin
                  state   <= R_START;
                  cnt     <= '0;
                  bit_cnt <= '0;
               end
            end
            R_START: begin
               // A start bit that is gone by mid-bit is a glitch, not a frame.
               if (cnt == HALF_LAST) begin
                  cnt   <= '0;
                  state <= (rxs == START_BIT) ? R_DATA : R_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            R_DATA: begin
               if (cnt == FULL_LAST) begin
                  cnt     <= '0;
                  shift   <= {rxs, shift[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'(DATA_BITS - 1)) begin
                     state <= R_STOP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            R_STOP: begin
               if (cnt == FULL_LAST) begin
                  cnt   <= '0;
                  state <= R_IDLE;
                  if (rxs == STOP_BIT) begin
                     data  <= shift;
                     valid <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/abc.sv
// rtl/abc.sv - serial byte repeater: slow 8N1 receiver feeding a one-byte holding register and fast 8N1 transmitter
module abc
   import abc_pkg::*;
#(
   parameter int RX_OVERSAMPLE = 16,
   parameter int TX_BIT_CYCLES = 1
) (
   input  logic clock,
   input  logic reset_,
   input  logic rxd,
   output logic txd
);

   localparam int            TCW     = (TX_BIT_CYCLES > 1) ? $clog2(TX_BIT_CYCLES) : 1;
   localparam logic [TCW-1:0] TX_LAST = TCW'(TX_BIT_CYCLES - 1);

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic [DATA_BITS-1:0] hold;
   logic                 full;
   tx_state_t            tx_state;
   logic [DATA_BITS-1:0] shift;
   logic [TCW-1:0]       cyc;
   logic [2:0]           bit_cnt;
   logic                 bit_end;
   logic                 load;

   abc_rx #(
      .RX_OVERSAMPLE(RX_OVERSAMPLE)
   ) u_rx (
      .clock (clock),
      .reset_(reset_),
      .rxd   (rxd),
      .data  (rx_data),
      .valid (rx_valid)
   );

   // Loading straight out of the stop bit lets a waiting byte go back-to-back.
   always_comb begin
      bit_end = (cyc == TX_LAST);
      load    = full && ((tx_state == T_IDLE) || ((tx_state == T_STOP) && bit_end));
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         hold     <= '0;
         full     <= 1'b0;
         tx_state <= T_IDLE;
         shift    <= '0;
         cyc      <= '0;
         bit_cnt  <= '0;
         txd      <= MARKING;
      end else begin
         // A receiver write on the load clock wins, keeping the new byte pending.
         if (rx_valid) begin
            hold <= rx_data;
            full <= 1'b1;
         end else if (load) begin
            full <= 1'b0;
         end

         if (load) begin
            shift    <= hold;
            tx_state <= T_START;
            txd      <= START_BIT;
            cyc      <= '0;
         end else begin
            case (tx_state)
               T_IDLE: txd <= MARKING;
               T_START: begin
                  if (bit_end) begin
                     cyc      <= '0;
                     bit_cnt  <= '0;
                     txd      <= shift[0];
                     tx_state <= T_DATA;
                  end else begin
                     cyc <= cyc + 1'b1;
                  end
               end
               T_DATA: begin
                  if (bit_end) begin
                     cyc <= '0;
                     if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        txd      <= STOP_BIT;
                        tx_state <= T_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shift   <= {1'b0, shift[DATA_BITS-1:1]};
                        txd     <= shift[1];
                     end
                  end else begin
                     cyc <= cyc + 1'b1;
                  end
               end
               T_STOP: begin
                  if (bit_end) begin
                     cyc      <= '0;
                     tx_state <= T_IDLE;
                  end else begin
                     cyc <= cyc + 1'b1;
                  end
               end
               default: tx_state <= T_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_abc.sv
// tb/tb_abc.sv - directed self-checking bench for the abc serial byte repeater
module tb_abc;

   logic clock  = 1'b0;
   logic reset_ = 1'b0;
   logic rxd    = 1'b1;
   logic txd;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   abc #(
      .RX_OVERSAMPLE(16),
      .TX_BIT_CYCLES(1)
   ) dut (
      .clock (clock),
      .reset_(reset_),
      .rxd   (rxd),
      .txd   (txd)
   );

   // txd frame decoder, one bit per clock
   logic       mon_busy = 1'b0;
   int         mon_cnt  = 0;
   int         mon_start = 0;
   logic [7:0] mon_shift = 8'h00;
   logic [7:0] byte_q[$];
   logic       stop_q[$];
   int         start_q[$];

   always @(negedge clock) begin
      if (!reset_) begin
         mon_busy = 1'b0;
      end else if (!mon_busy) begin
         if (txd === 1'b0) begin
            mon_busy  = 1'b1;
            mon_cnt   = 0;
            mon_start = cyc;
         end
      end else if (mon_cnt < 8) begin
         mon_shift = {txd, mon_shift[7:1]};
         mon_cnt++;
      end else begin
         byte_q.push_back(mon_shift);
         stop_q.push_back(txd);
         start_q.push_back(mon_start);
         mon_busy = 1'b0;
      end
   end

   task automatic clear_q();
      byte_q.delete();
      stop_q.delete();
      start_q.delete();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
      @(negedge clock);
      rxd = 1'b0;
      t0  = cyc;
      repeat (16) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (16) @(negedge clock);
      end
      rxd = stop;
      repeat (16) @(negedge clock);
      rxd = 1'b1;
   endtask

   task automatic expect_one(input string name, input logic [7:0] exp);
      n_checks++;
      if (byte_q.size() !== 1) begin
         n_fail++;
         $display("FAIL %s_count: got %0d frames, expected 1", name, byte_q.size());
      end
      if (byte_q.size() > 0) begin
         n_checks++;
         if (byte_q[0] !== exp) begin
            n_fail++;
            $display("FAIL %s_byte: got %02h, expected %02h", name, byte_q[0], exp);
         end
         n_checks++;
         if (stop_q[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_stop: got %b, expected 1", name, stop_q[0]);
         end
      end
   endtask

   task automatic test_reset();
      int bad;
      bad = 0;
      reset_ = 1'b0;
      rxd    = 1'b1;
      repeat (2) begin
         @(negedge clock);
         if (txd !== 1'b1) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL reset_hold: txd not 1 on %0d clocks, expected 0", bad);
      end
      reset_ = 1'b1;
      bad = 0;
      repeat (200) begin
         @(negedge clock);
         if (txd !== 1'b1) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL reset_idle: txd not 1 on %0d clocks, expected 0", bad);
      end
   endtask

   task automatic test_single_byte();
      int t0, lat;
      clear_q();
      send_frame(8'h0D, 1'b1, t0);
      repeat (20) @(negedge clock);
      expect_one("single", 8'h0D);
      if (start_q.size() > 0) begin
         // stop bit is sampled 155 clocks after the start edge is driven
         lat = start_q[0] - (t0 + 155);
         n_checks++;
         if (lat < 1 || lat > 2) begin
            n_fail++;
            $display("FAIL single_latency: got %0d clocks, expected 1..2", lat);
         end
      end
   endtask

   task automatic test_sweep();
      int t0;
      logic [7:0] exp;
      clear_q();
      for (int i = 0; i < 32; i++) begin
         exp = 8'((i * 17 + 13) % 256);
         send_frame(exp, 1'b1, t0);
         repeat (160) @(negedge clock);
      end
      n_checks++;
      if (byte_q.size() !== 32) begin
         n_fail++;
         $display("FAIL sweep_count: got %0d frames, expected 32", byte_q.size());
      end
      for (int i = 0; i < byte_q.size() && i < 32; i++) begin
         exp = 8'((i * 17 + 13) % 256);
         n_checks++;
         if (byte_q[i] !== exp || stop_q[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_%0d: got %02h stop %b, expected %02h stop 1", i, byte_q[i], stop_q[i], exp);
         end
      end
   endtask

   task automatic test_glitch();
      int t0;
      clear_q();
      @(negedge clock);
      rxd = 1'b0;
      repeat (3) @(negedge clock);
      rxd = 1'b1;
      repeat (100) @(negedge clock);
      n_checks++;
      if (byte_q.size() !== 0) begin
         n_fail++;
         $display("FAIL glitch_quiet: got %0d frames, expected 0", byte_q.size());
      end
      send_frame(8'hFF, 1'b1, t0);
      repeat (40) @(negedge clock);
      expect_one("glitch_after", 8'hFF);
   endtask

   task automatic test_framing();
      int t0;
      clear_q();
      send_frame(8'hA5, 1'b0, t0);
      repeat (100) @(negedge clock);
      n_checks++;
      if (byte_q.size() !== 0) begin
         n_fail++;
         $display("FAIL framing_drop: got %0d frames, expected 0", byte_q.size());
      end
      clear_q();
      send_frame(8'h3C, 1'b1, t0);
      repeat (40) @(negedge clock);
      expect_one("framing_after", 8'h3C);
   endtask

   task automatic test_reset_mid();
      int t0, w;
      clear_q();
      fork
         send_frame(8'h0F, 1'b1, t0);
         begin
            w = 0;
            while (txd !== 1'b0 && w < 400) begin
               @(negedge clock);
               w++;
            end
            n_checks++;
            if (w >= 400) begin
               n_fail++;
               $display("FAIL midreset_start: no txd start bit within 400 clocks");
            end else begin
               repeat (5) @(negedge clock);
               n_checks++;
               if (txd !== 1'b0) begin
                  n_fail++;
                  $display("FAIL midreset_bit4: got %b, expected 0", txd);
               end
               #2 reset_ = 1'b0;
               #1;
               n_checks++;
               if (txd !== 1'b1) begin
                  n_fail++;
                  $display("FAIL midreset_txd: got %b, expected 1", txd);
               end
               repeat (2) @(negedge clock);
               reset_ = 1'b1;
            end
         end
      join
      reset_ = 1'b1;
      repeat (20) @(negedge clock);
      clear_q();
      send_frame(8'h55, 1'b1, t0);
      repeat (40) @(negedge clock);
      expect_one("midreset_after", 8'h55);
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_sweep();
      test_glitch();
      test_framing();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
